// File: rtl/pulse_hs_rx.sv
`default_nettype none
// ============================================================================
// Module      : pulse_hs_rx
// Description : Receive end of a 4-phase req/ack pulse-crossing protocol.
//               Synchronises an asynchronous req level, returns a registered
//               ack level, and turns every accepted handshake into exactly one
//               single-cycle pulse_out in the local clock domain.  Bursts are
//               queued in a saturating pending counter.  After each pulse, a
//               programmable number of idle cycles is forced before the next.
// Ports       : clk        in   local clock
//               rst        in   asynchronous reset, active-high
//               req_async  in   4-phase request level (foreign domain)
//               ack        out  registered acknowledge level to the source
//               pulse_out  out  registered one-cycle event pulse
//               pending    out  accepted events not yet emitted
//               overflow   out  sticky: an event was dropped (queue full)
//               ovf_clr    in   synchronous clear of overflow
//               evt_count  out  32-bit accepted-handshake counter
//                               (only when PULSE_STATS_EN is defined)
// Options     : `define PULSE_STATS_EN to add the evt_count port and counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_hs_rx #(
    parameter int   SYNC_STAGES = 2,
    parameter int   MIN_GAP     = 0,
    parameter int   PEND_W      = 4,
    parameter logic REQ_INIT    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_async,
    output logic              ack,
    output logic              pulse_out,
    output logic [PEND_W-1:0] pending,
    output logic              overflow,
    input  logic              ovf_clr
`ifdef PULSE_STATS_EN
    ,
    output logic [31:0]       evt_count
`endif
);

    // A gap counter of at least one bit keeps the MIN_GAP=0 build legal;
    // it then simply never leaves zero.
    localparam int                GAP_W      = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
    localparam logic [GAP_W-1:0]  GAP_LOAD   = GAP_W'(MIN_GAP);
    localparam logic [PEND_W-1:0] PEND_MAX   = {PEND_W{1'b1}};
    localparam logic              HOLD_AFTER = (MIN_GAP > 0);

    typedef enum logic [0:0] {
        WAIT_REQ = 1'b0,
        ACKED    = 1'b1
    } state_t;

    // Starting in ACKED when req is assumed high at reset means the
    // already-high request is not mistaken for a new handshake.
    localparam state_t STATE_RST = REQ_INIT ? ACKED : WAIT_REQ;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic                   ack_q, ack_d;
    logic                   pulse_q, pulse_d;
    logic [PEND_W-1:0]      pending_q, pending_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic                   overflow_q, overflow_d;

    logic                   req_s;
    logic                   enq;
    logic                   deq;
    logic                   ovf_set;

    // ------------------------------------------------------------------
    // Synchroniser and handshake FSM
    // ------------------------------------------------------------------
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], req_async};
        req_s   = sync_q[SYNC_STAGES-1];
        state_d = state_q;
        ack_d   = ack_q;
        enq     = 1'b0;
        case (state_q)
            WAIT_REQ: begin
                if (req_s) begin
                    state_d = ACKED;
                    ack_d   = 1'b1;
                    enq     = 1'b1;
                end
            end
            ACKED: begin
                if (!req_s) begin
                    state_d = WAIT_REQ;
                    ack_d   = 1'b0;
                end
            end
            default: begin
                state_d = STATE_RST;
                ack_d   = REQ_INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Emission, gap timer, pending queue and overflow
    // ------------------------------------------------------------------
    always_comb begin
        // The pulse and the decrement of pending share one edge, so a
        // dequeue is exactly "pulse_out will be high next cycle".
        deq     = (pending_q != '0) && (gap_q == '0) && !(HOLD_AFTER && pulse_q);
        pulse_d = deq;

        gap_d = gap_q;
        if (deq) begin
            gap_d = GAP_LOAD;
        end else if (gap_q != '0) begin
            gap_d = gap_q - GAP_W'(1);
        end

        pending_d = pending_q;
        ovf_set   = 1'b0;
        if (enq && !deq) begin
            if (pending_q == PEND_MAX) begin
                ovf_set = 1'b1;
            end else begin
                pending_d = pending_q + PEND_W'(1);
            end
        end else if (!enq && deq) begin
            pending_d = pending_q - PEND_W'(1);
        end

        // Set takes priority over a coincident clear.
        overflow_d = overflow_q;
        if (ovf_clr) begin
            overflow_d = 1'b0;
        end
        if (ovf_set) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= {SYNC_STAGES{REQ_INIT}};
            state_q    <= STATE_RST;
            ack_q      <= REQ_INIT;
            pulse_q    <= 1'b0;
            pending_q  <= '0;
            gap_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            ack_q      <= ack_d;
            pulse_q    <= pulse_d;
            pending_q  <= pending_d;
            gap_q      <= gap_d;
            overflow_q <= overflow_d;
        end
    end

    assign ack       = ack_q;
    assign pulse_out = pulse_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;

`ifdef PULSE_STATS_EN
    // Counts every accepted handshake, dropped ones included; wraps freely.
    logic [31:0] evt_count_q, evt_count_d;

    always_comb begin
        evt_count_d = evt_count_q;
        if (enq) begin
            evt_count_d = evt_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_count_q <= 32'd0;
        end else begin
            evt_count_q <= evt_count_d;
        end
    end

    assign evt_count = evt_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pulse_hs_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_hs_rx
// Description : Directed self-checking bench for pulse_hs_rx.  Four instances
//               cover the default build, MIN_GAP=5, PEND_W=2/MIN_GAP=63 and
//               REQ_INIT=1.  evt_count is checked when PULSE_STATS_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_hs_rx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ovf_clr = 1'b0;

    logic req0 = 1'b0, req_g = 1'b0, req_o = 1'b0, req_i = 1'b1;
    logic ack0, ack_g, ack_o, ack_i;
    logic pul0, pul_g, pul_o, pul_i;
    logic [3:0] pend0, pend_g, pend_i;
    logic [1:0] pend_o;
    logic ovf0, ovf_g, ovf_o, ovf_i;
`ifdef PULSE_STATS_EN
    logic [31:0] evt0, evt_g, evt_o, evt_i;
`endif

    always #5 clk = ~clk;

    pulse_hs_rx u_def (
        .clk(clk), .rst(rst), .req_async(req0), .ack(ack0), .pulse_out(pul0),
        .pending(pend0), .overflow(ovf0), .ovf_clr(ovf_clr)
`ifdef PULSE_STATS_EN
        , .evt_count(evt0)
`endif
    );

    pulse_hs_rx #(.MIN_GAP(5)) u_gap (
        .clk(clk), .rst(rst), .req_async(req_g), .ack(ack_g), .pulse_out(pul_g),
        .pending(pend_g), .overflow(ovf_g), .ovf_clr(ovf_clr)
`ifdef PULSE_STATS_EN
        , .evt_count(evt_g)
`endif
    );

    pulse_hs_rx #(.PEND_W(2), .MIN_GAP(63)) u_ovf (
        .clk(clk), .rst(rst), .req_async(req_o), .ack(ack_o), .pulse_out(pul_o),
        .pending(pend_o), .overflow(ovf_o), .ovf_clr(ovf_clr)
`ifdef PULSE_STATS_EN
        , .evt_count(evt_o)
`endif
    );

    pulse_hs_rx #(.REQ_INIT(1'b1)) u_ini (
        .clk(clk), .rst(rst), .req_async(req_i), .ack(ack_i), .pulse_out(pul_i),
        .pending(pend_i), .overflow(ovf_i), .ovf_clr(ovf_clr)
`ifdef PULSE_STATS_EN
        , .evt_count(evt_i)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int n0, n_g, n_o, n_i;
    int last_g, min_g, last_o, min_o;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        n0 = 0; n_g = 0; n_o = 0; n_i = 0;
        last_g = -1; min_g = 1000000;
        last_o = -1; min_o = 1000000;
    endtask

    // Advance one clock; outputs are sampled at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (pul0) n0++;
        if (pul_i) n_i++;
        if (pul_g) begin
            n_g++;
            if (last_g >= 0 && (cyc - last_g) < min_g) min_g = cyc - last_g;
            last_g = cyc;
        end
        if (pul_o) begin
            n_o++;
            if (last_o >= 0 && (cyc - last_o) < min_o) min_o = cyc - last_o;
            last_o = cyc;
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    function automatic logic ack_of(input int w);
        case (w)
            0:       return ack0;
            1:       return ack_g;
            2:       return ack_o;
            default: return ack_i;
        endcase
    endfunction

    task automatic set_req(input int w, input logic v);
        case (w)
            0:       req0  = v;
            1:       req_g = v;
            2:       req_o = v;
            default: req_i = v;
        endcase
    endtask

    task automatic wait_ack(input int w, input logic lvl, input string tag);
        for (int k = 0; k < 20 && ack_of(w) !== lvl; k++) tick();
        check(tag, {31'd0, ack_of(w)}, {31'd0, lvl});
    endtask

    task automatic hs(input int w);
        set_req(w, 1'b1);
        wait_ack(w, 1'b1, "hs_ack_hi");
        set_req(w, 1'b0);
        wait_ack(w, 1'b0, "hs_ack_lo");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        clear_counts();
    endtask

    initial begin
        clear_counts();
        @(negedge clk);
        do_reset();

        // ---- 1: default latency ------------------------------------------
        check("rst_ack",      {31'd0, ack0}, 32'd0);
        check("rst_pulse",    {31'd0, pul0}, 32'd0);
        check("rst_pending",  {28'd0, pend0}, 32'd0);
        check("rst_overflow", {31'd0, ovf0}, 32'd0);
        req0 = 1'b1;
        tick();  check("t1_e1_ack", {31'd0, ack0}, 32'd0);
        tick();  check("t1_e2_ack", {31'd0, ack0}, 32'd0);
        tick();  check("t1_e3_ack", {31'd0, ack0}, 32'd1);
                 check("t1_e3_pend", {28'd0, pend0}, 32'd1);
                 check("t1_e3_pulse", {31'd0, pul0}, 32'd0);
        tick();  check("t1_e4_pulse", {31'd0, pul0}, 32'd1);
                 check("t1_e4_pend", {28'd0, pend0}, 32'd0);
        tick();  check("t1_e5_pulse", {31'd0, pul0}, 32'd0);
        req0 = 1'b0;
        tick();  check("t1_f1_ack", {31'd0, ack0}, 32'd1);
        tick();  check("t1_f2_ack", {31'd0, ack0}, 32'd1);
        tick();  check("t1_f3_ack", {31'd0, ack0}, 32'd0);
        ticks(6);
        check("t1_pulses", n0, 32'd1);

        // ---- 2: MIN_GAP=5 ------------------------------------------------
        do_reset();
        hs(1); hs(1); hs(1);
        ticks(30);
        check("t2_pulses",  n_g, 32'd3);
        check("t2_spacing", {31'd0, (min_g >= 6)}, 32'd1);
        check("t2_pending", {28'd0, pend_g}, 32'd0);

        // ---- 3 / 6: saturation, overflow, stats ------------------------------
        do_reset();
        hs(2);
        hs(2);
        check("t3_pend_1", {30'd0, pend_o}, 32'd1);
        check("t3_held",   n_o, 32'd1);
        hs(2); hs(2); hs(2); hs(2);
        check("t3_pend_sat", {30'd0, pend_o}, 32'd3);
        check("t3_ovf_set",  {31'd0, ovf_o}, 32'd1);
        check("t3_pulses_a", n_o, 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t3_ovf_clr", {31'd0, ovf_o}, 32'd0);
        ticks(220);
        check("t3_pulses_b", n_o, 32'd4);
        check("t3_spacing",  min_o, 32'd64);
        check("t3_pend_0",   {30'd0, pend_o}, 32'd0);
        hs(2); hs(2); hs(2); hs(2);
        ticks(220);
        check("t6_pulses",   n_o, 32'd8);
        check("t6_ovf",      {31'd0, ovf_o}, 32'd0);
        check("t6_pend_0",   {30'd0, pend_o}, 32'd0);
`ifdef PULSE_STATS_EN
        check("t6_evt_count", evt_o, 32'd10);
        check("t6_evt_def",   evt0, 32'd0);
`endif

        // ---- 4: REQ_INIT=1 ------------------------------------------------
        req_i = 1'b1;
        do_reset();
        check("t4_rst_ack", {31'd0, ack_i}, 32'd1);
        ticks(6);
        check("t4_no_pulse", n_i, 32'd0);
        check("t4_pend",     {28'd0, pend_i}, 32'd0);
        req_i = 1'b0;
        wait_ack(3, 1'b0, "t4_ack_lo");
        ticks(4);
        check("t4_no_pulse_fall", n_i, 32'd0);
        req_i = 1'b1;
        wait_ack(3, 1'b1, "t4_ack_hi");
        ticks(4);
        check("t4_one_pulse", n_i, 32'd1);

        // ---- 5: reset mid-operation ----------------------------------------
        do_reset();
        hs(2);
        hs(2);
        req_o = 1'b1;
        wait_ack(2, 1'b1, "t5_ack_hi");
        check("t5_pend_2", {30'd0, pend_o}, 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_ack",   {31'd0, ack_o}, 32'd0);
        check("t5_async_pend",  {30'd0, pend_o}, 32'd0);
        check("t5_async_pulse", {31'd0, pul_o}, 32'd0);
        req_o = 1'b0;
        ticks(3);
        rst = 1'b0;
        clear_counts();
        ticks(100);
        check("t5_no_pulse", n_o, 32'd0);
        hs(2);
        ticks(4);
        check("t5_new_pulse", n_o, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
